// File: rtl/host_cmd_controller_pkg.sv
// Shared types and constants for the host command front end of the downscaling accelerator.
package host_cmd_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3
    } state_e;

    localparam int BIT_CFG        = 31;
    localparam int BIT_REG        = 30;
    localparam int BIT_RES        = 29;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [31:0] REG_DEFAULT = 32'hDEADC0DE;

    typedef enum logic [7:0] {
        REG_WIDTH   = 8'd0,
        REG_HEIGHT  = 8'd1,
        REG_SIMD    = 8'd2,
        REG_SCALE   = 8'd3,
        REG_MODE    = 8'd4,
        REG_DEBUG   = 8'd5,
        REG_RUNNING = 8'd6,
        REG_LEN     = 8'd7,
        REG_PIX_CNT = 8'd8,
        REG_STATUS  = 8'd9,
        REG_WR_PTR  = 8'd10
    } reg_code_e;

    // Layout of instruction bits [30:0] for a CONFIG word.
    typedef struct packed {
        logic       mode;
        logic       debug;
        logic [8:0] width;
        logic [8:0] height;
        logic [2:0] n_simd;
        logic [7:0] scale;
    } cfg_t;

    function automatic logic [3:0] lane_mask(input logic [17:0] rem);
        if (rem >= 18'(BYTES_PER_WORD)) return 4'hF;
        case (rem[1:0])
            2'd0:    return 4'h0;
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

    function automatic logic [17:0] lane_count(input logic [17:0] rem);
        return (rem >= 18'(BYTES_PER_WORD)) ? 18'(BYTES_PER_WORD) : rem;
    endfunction

endpackage

// File: rtl/host_cmd_controller_if.sv
// Image RAM port: the controller masters it, the RAM (or bench model) is the slave.
interface host_cmd_controller_if #(
    parameter int ADDR_W = 16
);
    logic              mem_we;
    logic [3:0]        mem_byte_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (output mem_we, mem_byte_en, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_we, mem_byte_en, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/host_cmd_controller_strobe_sync_edge.sv
// Synchronises an asynchronous host strobe and flags its rising edge for one cycle.
module host_cmd_controller_strobe_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strb_i,
    output logic edge_o
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous cycle's value of its neighbour.
            sync_q <= {sync_q[STAGES-2:0], strb_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] & ~last_q;
endmodule

// File: rtl/host_cmd_controller.sv
// Host command/data front end: decodes host words, holds image config, streams pixels to RAM,
// serves register/image readback and sequences start/done with the core.
module host_cmd_controller
    import host_cmd_controller_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RES_BASE    = 'h8000,
    parameter int unsigned       MAX_PIXELS  = 65536,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_wr_strb,
    input  logic                        i_rd_strb,
    input  logic [31:0]                 i_instr,
    input  logic                        i_core_done,
    host_cmd_controller_if.master       mem_bus,
    output logic                        o_mode_select,
    output logic                        o_debug_mode,
    output logic [8:0]                  o_img_width,
    output logic [8:0]                  o_img_height,
    output logic [2:0]                  o_n_simd,
    output logic [7:0]                  o_scale_factor,
    output logic                        o_start,
    output logic [31:0]                 o_response_data,
    output logic                        o_rsp_valid,
    output logic                        o_waiting_command
);
    logic wr_edge, rd_edge;

    host_cmd_controller_strobe_sync_edge #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk(clk), .reset_n(reset_n), .strb_i(i_wr_strb), .edge_o(wr_edge));
    host_cmd_controller_strobe_sync_edge #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk(clk), .reset_n(reset_n), .strb_i(i_rd_strb), .edge_o(rd_edge));

    state_e            state_q;
    cfg_t              cfg_q;
    logic              err_q, waiting_q, start_q, we_q, rsp_valid_q;
    logic              rd_armed_q, mem_pend_q, mem_sel_q;
    logic [3:0]        byte_en_q;
    logic [31:0]       wdata_q, rsp_q;
    logic [17:0]       len_q, pix_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q, waddr_q, rd_ptr_q;

    cfg_t        cfg_d;
    logic [17:0] len_d, rem_d, pix_cnt_d;
    logic        cfg_ok_d, idle_or_ready;
    logic [31:0] reg_val;

    assign cfg_d         = cfg_t'(i_instr[30:0]);
    assign len_d         = {9'd0, cfg_d.width} * {9'd0, cfg_d.height};
    assign cfg_ok_d      = (cfg_d.width != '0) && (cfg_d.height != '0) && (32'(len_d) <= MAX_PIXELS);
    assign rem_d         = len_q - pix_cnt_q;
    assign pix_cnt_d     = pix_cnt_q + lane_count(rem_d);
    assign idle_or_ready = (state_q == ST_IDLE) || (state_q == ST_READY);

    always_comb begin
        // NOTE: default first so no path leaves reg_val unassigned and infers a latch.
        reg_val = REG_DEFAULT;
        case (i_instr[7:0])
            REG_WIDTH:   reg_val = {23'd0, cfg_q.width};
            REG_HEIGHT:  reg_val = {23'd0, cfg_q.height};
            REG_SIMD:    reg_val = {29'd0, cfg_q.n_simd};
            REG_SCALE:   reg_val = {24'd0, cfg_q.scale};
            REG_MODE:    reg_val = {31'd0, cfg_q.mode};
            REG_DEBUG:   reg_val = {31'd0, cfg_q.debug};
            REG_RUNNING: reg_val = {31'd0, state_q == ST_RUN};
            REG_LEN:     reg_val = {14'd0, len_q};
            REG_PIX_CNT: reg_val = {14'd0, pix_cnt_q};
            REG_STATUS:  reg_val = {err_q, 28'd0, state_q};
            REG_WR_PTR:  reg_val = 32'(wr_ptr_q);
            default:     reg_val = REG_DEFAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            waiting_q   <= 1'b1;
            start_q     <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_armed_q  <= 1'b0;
            mem_pend_q  <= 1'b0;
            mem_sel_q   <= 1'b0;
            byte_en_q   <= '0;
            wdata_q     <= '0;
            rsp_q       <= '0;
            len_q       <= '0;
            pix_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            waddr_q     <= '0;
            rd_ptr_q    <= '0;
        end else begin
            start_q     <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_pend_q  <= 1'b0;

            // RAM data is passed straight through for one cycle, then held here.
            if (mem_sel_q) begin
                rsp_q     <= mem_bus.mem_rdata;
                mem_sel_q <= 1'b0;
            end
            if (mem_pend_q) begin
                rsp_valid_q <= 1'b1;
                mem_sel_q   <= 1'b1;
            end

            if (wr_edge) begin
                if (state_q == ST_RX) begin
                    we_q      <= 1'b1;
                    waddr_q   <= wr_ptr_q;
                    wdata_q   <= i_instr;
                    byte_en_q <= lane_mask(rem_d);
                    wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
                    pix_cnt_q <= pix_cnt_d;
                    if (pix_cnt_d == len_q) begin
                        state_q   <= ST_READY;
                        waiting_q <= 1'b1;
                    end
                end else if (i_instr[BIT_CFG]) begin
                    if (i_instr[30:0] != '0) begin
                        if (idle_or_ready && cfg_ok_d) begin
                            cfg_q     <= cfg_d;
                            len_q     <= len_d;
                            pix_cnt_q <= '0;
                            wr_ptr_q  <= '0;
                            err_q     <= 1'b0;
                            state_q   <= ST_RX;
                            waiting_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (state_q == ST_READY) begin
                        start_q   <= 1'b1;
                        state_q   <= ST_RUN;
                        waiting_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else if (i_instr[BIT_REG]) begin
                    rsp_q       <= reg_val;
                    rsp_valid_q <= 1'b1;
                    mem_sel_q   <= 1'b0;
                end else if (idle_or_ready) begin
                    rd_ptr_q   <= i_instr[BIT_RES] ? RES_BASE : '0;
                    rd_armed_q <= 1'b1;
                    mem_pend_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
                // A read edge colliding with a write edge is dropped and flagged.
                if (rd_edge) err_q <= 1'b1;
            end else if (rd_edge && idle_or_ready && rd_armed_q) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                mem_pend_q <= 1'b1;
            end

            if (state_q == ST_RUN && i_core_done) begin
                state_q   <= ST_IDLE;
                waiting_q <= 1'b1;
            end
        end
    end

    assign mem_bus.mem_we      = we_q;
    assign mem_bus.mem_byte_en = byte_en_q;
    assign mem_bus.mem_addr    = we_q ? waddr_q : rd_ptr_q;
    assign mem_bus.mem_wdata   = wdata_q;

    assign o_mode_select     = cfg_q.mode;
    assign o_debug_mode      = cfg_q.debug;
    assign o_img_width       = cfg_q.width;
    assign o_img_height      = cfg_q.height;
    assign o_n_simd          = cfg_q.n_simd;
    assign o_scale_factor    = cfg_q.scale;
    assign o_start           = start_q;
    assign o_response_data   = mem_sel_q ? mem_bus.mem_rdata : rsp_q;
    assign o_rsp_valid       = rsp_valid_q;
    assign o_waiting_command = waiting_q;
endmodule
